// File: rtl/ysyx22040413_idu_stage.sv
// ysyx22040413 decode stage: instruction queue, head decode,
// register-file read and registered bundle toward the EXU.
module ysyx22040413_idu_stage #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rs1idx,
  output logic [4:0]      rs2idx,
  input  logic [XLEN-1:0] rs1data,
  input  logic [XLEN-1:0] rs2data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic            out_rs1en,
  output logic            out_rs2en,
  output logic            out_rdwen,
  output logic [4:0]      out_rdwidx,
  output logic [XLEN-1:0] out_alu_op1,
  output logic [XLEN-1:0] out_alu_op2,
  output logic [XLEN-1:0] out_pc_op1,
  output logic [XLEN-1:0] out_pc_op2,
  output logic            out_pc_update,
  output logic            out_jalr,
  output logic            out_alu_add,
  output logic            out_store,
  output logic            out_illegal
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_N = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            rs1en;
    logic            rs2en;
    logic            rdwen;
    logic [4:0]      rdwidx;
    logic [XLEN-1:0] alu_op1;
    logic [XLEN-1:0] alu_op2;
    logic [XLEN-1:0] pc_op1;
    logic [XLEN-1:0] pc_op2;
    logic            pc_update;
    logic            jalr;
    logic            alu_add;
    logic            store;
    logic            illegal;
  } bundle_t;

  logic [31:0]     mem_inst [DEPTH];
  logic [XLEN-1:0] mem_pc   [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [AW:0]     count;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  assign full     = (count == FULL_N);
  assign empty    = (count == '0);
  assign in_ready = !rst && !full;
  assign push     = in_valid && in_ready;
  assign pop      = !empty && (!out_valid || out_ready);

  // store data is carried by a later stage, not this bundle
  logic unused_rs2data;
  assign unused_rs2data = ^rs2data;

  logic [31:0]     inst;
  logic [XLEN-1:0] pc;
  assign inst   = mem_inst[rptr];
  assign pc     = mem_pc[rptr];
  assign rs1idx = inst[19:15];
  assign rs2idx = inst[24:20];

  logic [6:0] opc;
  logic [2:0] f3;
  assign opc = inst[6:0];
  assign f3  = inst[14:12];

  logic is_addi, is_auipc, is_lui, is_jal, is_jalr, is_sd;
  assign is_addi  = (opc == 7'b0010011) && (f3 == 3'b000);
  assign is_auipc = (opc == 7'b0010111);
  assign is_lui   = (opc == 7'b0110111);
  assign is_jal   = (opc == 7'b1101111);
  assign is_jalr  = (opc == 7'b1100111) && (f3 == 3'b000);
  assign is_sd    = (opc == 7'b0100011) && (f3 == 3'b011)
                 && (XLEN == 64);

  logic [XLEN-1:0] i_imm, u_imm, s_imm, j_imm;
  assign i_imm = XLEN'($signed(inst[31:20]));
  assign u_imm = XLEN'($signed({inst[31:12], 12'b0}));
  assign s_imm = XLEN'($signed({inst[31:25], inst[11:7]}));
  assign j_imm = XLEN'($signed({inst[31], inst[19:12],
                                inst[20], inst[30:21], 1'b0}));

  bundle_t dec;
  bundle_t bund;

  // decode the queue head into a bundle
  always_comb begin
    dec    = '0;
    dec.pc = pc;
    unique case (1'b1)
      is_addi: begin
        dec.alu_op1 = rs1data;
        dec.alu_op2 = i_imm;
        dec.rs1en   = 1'b1;
        dec.rdwen   = 1'b1;
        dec.alu_add = 1'b1;
      end
      is_auipc: begin
        dec.alu_op1 = pc;
        dec.alu_op2 = u_imm;
        dec.rdwen   = 1'b1;
        dec.alu_add = 1'b1;
      end
      is_lui: begin
        dec.alu_op2 = u_imm;
        dec.rdwen   = 1'b1;
        dec.alu_add = 1'b1;
      end
      is_jal: begin
        dec.alu_op1   = pc;
        dec.alu_op2   = XLEN'(4);
        dec.pc_op1    = pc;
        dec.pc_op2    = j_imm;
        dec.rdwen     = 1'b1;
        dec.pc_update = 1'b1;
        dec.alu_add   = 1'b1;
      end
      is_jalr: begin
        dec.alu_op1   = pc;
        dec.alu_op2   = XLEN'(4);
        dec.pc_op1    = rs1data;
        dec.pc_op2    = i_imm;
        dec.rs1en     = 1'b1;
        dec.rdwen     = 1'b1;
        dec.pc_update = 1'b1;
        dec.jalr      = 1'b1;
        dec.alu_add   = 1'b1;
      end
      is_sd: begin
        dec.alu_op1 = rs1data;
        dec.alu_op2 = s_imm;
        dec.rs1en   = 1'b1;
        dec.rs2en   = 1'b1;
        dec.store   = 1'b1;
        dec.alu_add = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.rdwidx = dec.illegal ? 5'd0 : inst[11:7];
    dec.rdwen  = dec.rdwen && (inst[11:7] != 5'd0);
  end

  // queue storage, written on accepted pushes
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_inst[wptr] <= in_inst;
      mem_pc[wptr]   <= in_pc;
    end
  end

  // queue pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // output register toward the EXU
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      bund      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (pop) begin
      out_valid <= 1'b1;
      bund      <= dec;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_pc        = bund.pc;
  assign out_rs1en     = bund.rs1en;
  assign out_rs2en     = bund.rs2en;
  assign out_rdwen     = bund.rdwen;
  assign out_rdwidx    = bund.rdwidx;
  assign out_alu_op1   = bund.alu_op1;
  assign out_alu_op2   = bund.alu_op2;
  assign out_pc_op1    = bund.pc_op1;
  assign out_pc_op2    = bund.pc_op2;
  assign out_pc_update = bund.pc_update;
  assign out_jalr      = bund.jalr;
  assign out_alu_add   = bund.alu_add;
  assign out_store     = bund.store;
  assign out_illegal   = bund.illegal;

endmodule

// File: tb/tb_ysyx22040413_idu_stage.sv
// Directed bench for ysyx22040413_idu_stage: decode table on
// XLEN=64 and XLEN=32 instances plus queue/flush/reset sequences.
module tb_ysyx22040413_idu_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // XLEN=64 instance (a_*)
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_inst;
  logic [63:0] a_in_pc, a_rs1data, a_rs2data, a_out_pc;
  logic [4:0]  a_rs1idx, a_rs2idx, a_out_rdwidx;
  logic        a_out_rs1en, a_out_rs2en, a_out_rdwen;
  logic [63:0] a_out_alu_op1, a_out_alu_op2, a_out_pc_op1, a_out_pc_op2;
  logic        a_out_pc_update, a_out_jalr, a_out_alu_add;
  logic        a_out_store, a_out_illegal;

  // XLEN=32 instance (b_*)
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_inst;
  logic [31:0] b_in_pc, b_rs1data, b_rs2data, b_out_pc;
  logic [4:0]  b_rs1idx, b_rs2idx, b_out_rdwidx;
  logic        b_out_rs1en, b_out_rs2en, b_out_rdwen;
  logic [31:0] b_out_alu_op1, b_out_alu_op2, b_out_pc_op1, b_out_pc_op2;
  logic        b_out_pc_update, b_out_jalr, b_out_alu_add;
  logic        b_out_store, b_out_illegal;

  ysyx22040413_idu_stage #(.XLEN(64), .DEPTH(2)) dut64 (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_inst(a_in_inst), .in_pc(a_in_pc),
    .rs1idx(a_rs1idx), .rs2idx(a_rs2idx),
    .rs1data(a_rs1data), .rs2data(a_rs2data),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_pc(a_out_pc), .out_rs1en(a_out_rs1en),
    .out_rs2en(a_out_rs2en), .out_rdwen(a_out_rdwen),
    .out_rdwidx(a_out_rdwidx),
    .out_alu_op1(a_out_alu_op1), .out_alu_op2(a_out_alu_op2),
    .out_pc_op1(a_out_pc_op1), .out_pc_op2(a_out_pc_op2),
    .out_pc_update(a_out_pc_update), .out_jalr(a_out_jalr),
    .out_alu_add(a_out_alu_add), .out_store(a_out_store),
    .out_illegal(a_out_illegal)
  );

  ysyx22040413_idu_stage #(.XLEN(32), .DEPTH(2)) dut32 (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_inst(b_in_inst), .in_pc(b_in_pc),
    .rs1idx(b_rs1idx), .rs2idx(b_rs2idx),
    .rs1data(b_rs1data), .rs2data(b_rs2data),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_pc(b_out_pc), .out_rs1en(b_out_rs1en),
    .out_rs2en(b_out_rs2en), .out_rdwen(b_out_rdwen),
    .out_rdwidx(b_out_rdwidx),
    .out_alu_op1(b_out_alu_op1), .out_alu_op2(b_out_alu_op2),
    .out_pc_op1(b_out_pc_op1), .out_pc_op2(b_out_pc_op2),
    .out_pc_update(b_out_pc_update), .out_jalr(b_out_jalr),
    .out_alu_add(b_out_alu_add), .out_store(b_out_store),
    .out_illegal(b_out_illegal)
  );

  // {rs1en, rs2en, rdwen, pc_update, jalr, alu_add, store, illegal}
  logic [7:0] a_flags, b_flags;
  assign a_flags = {a_out_rs1en, a_out_rs2en, a_out_rdwen,
                    a_out_pc_update, a_out_jalr, a_out_alu_add,
                    a_out_store, a_out_illegal};
  assign b_flags = {b_out_rs1en, b_out_rs2en, b_out_rdwen,
                    b_out_pc_update, b_out_jalr, b_out_alu_add,
                    b_out_store, b_out_illegal};

  typedef struct {
    bit          x32;
    logic [31:0] inst;
    logic [63:0] pc;
    logic [4:0]  e_rs1idx;
    logic [4:0]  e_rs2idx;
    logic [4:0]  e_rd;
    logic [63:0] e_op1;
    logic [63:0] e_op2;
    logic [63:0] e_pc1;
    logic [63:0] e_pc2;
    logic [7:0]  e_flags;
  } vec_t;

  vec_t tbl [12];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_addi(input int k);
    return {12'(k), 5'd2, 3'b000, 5'd1, 7'h13};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [63:0] g_pc, g_op1, g_op2, g_pc1, g_pc2;
    logic [7:0]  g_fl;
    logic [4:0]  g_rd, g_r1, g_r2;
    logic        g_v;
    if (v.x32) begin
      b_in_valid = 1'b1; b_in_inst = v.inst; b_in_pc = v.pc[31:0];
    end else begin
      a_in_valid = 1'b1; a_in_inst = v.inst; a_in_pc = v.pc;
    end
    tick();
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    g_r1 = v.x32 ? b_rs1idx : a_rs1idx;
    g_r2 = v.x32 ? b_rs2idx : a_rs2idx;
    chk($sformatf("v%0d rs1idx", idx), 64'(g_r1), 64'(v.e_rs1idx));
    chk($sformatf("v%0d rs2idx", idx), 64'(g_r2), 64'(v.e_rs2idx));
    tick();
    g_v   = v.x32 ? b_out_valid : a_out_valid;
    g_pc  = v.x32 ? 64'(b_out_pc) : a_out_pc;
    g_op1 = v.x32 ? 64'(b_out_alu_op1) : a_out_alu_op1;
    g_op2 = v.x32 ? 64'(b_out_alu_op2) : a_out_alu_op2;
    g_pc1 = v.x32 ? 64'(b_out_pc_op1) : a_out_pc_op1;
    g_pc2 = v.x32 ? 64'(b_out_pc_op2) : a_out_pc_op2;
    g_rd  = v.x32 ? b_out_rdwidx : a_out_rdwidx;
    g_fl  = v.x32 ? b_flags : a_flags;
    chk($sformatf("v%0d out_valid", idx), 64'(g_v), 64'd1);
    chk($sformatf("v%0d out_pc", idx), g_pc, v.pc);
    chk($sformatf("v%0d alu_op1", idx), g_op1, v.e_op1);
    chk($sformatf("v%0d alu_op2", idx), g_op2, v.e_op2);
    chk($sformatf("v%0d pc_op1", idx), g_pc1, v.e_pc1);
    chk($sformatf("v%0d pc_op2", idx), g_pc2, v.e_pc2);
    chk($sformatf("v%0d rdwidx", idx), 64'(g_rd), 64'(v.e_rd));
    chk($sformatf("v%0d flags", idx), 64'(g_fl), 64'(v.e_flags));
    tick();
    g_v = v.x32 ? b_out_valid : a_out_valid;
    chk($sformatf("v%0d drained", idx), 64'(g_v), 64'd0);
  endtask

  initial begin
    int acc;
    int seen;
    logic fire;

    tbl[0]  = '{0, 32'h00510093, 64'h80000000, 5'd2, 5'd5, 5'd1,
                64'd10, 64'd5, 64'd0, 64'd0, 8'b10100100};
    tbl[1]  = '{0, 32'h008000EF, 64'h80000000, 5'd0, 5'd8, 5'd1,
                64'h80000000, 64'd4, 64'h80000000, 64'd8, 8'b00110100};
    tbl[2]  = '{0, 32'h123452B7, 64'h80000004, 5'd8, 5'd3, 5'd5,
                64'd0, 64'h12345000, 64'd0, 64'd0, 8'b00100100};
    tbl[3]  = '{0, 32'h00113423, 64'h80000008, 5'd2, 5'd1, 5'd8,
                64'd10, 64'd8, 64'd0, 64'd0, 8'b11000110};
    tbl[4]  = '{0, 32'h00000000, 64'h8000000C, 5'd0, 5'd0, 5'd0,
                64'd0, 64'd0, 64'd0, 64'd0, 8'b00000001};
    tbl[5]  = '{0, 32'h00100013, 64'h80000010, 5'd0, 5'd1, 5'd0,
                64'd10, 64'd1, 64'd0, 64'd0, 8'b10000100};
    tbl[6]  = '{0, 32'h00001197, 64'h80000014, 5'd0, 5'd0, 5'd3,
                64'h80000014, 64'h1000, 64'd0, 64'd0, 8'b00100100};
    tbl[7]  = '{0, 32'hFFC100E7, 64'h80000020, 5'd2, 5'd28, 5'd1,
                64'h80000020, 64'd4, 64'd10,
                64'hFFFFFFFFFFFFFFFC, 8'b10111100};
    tbl[8]  = '{0, 32'hFFF00093, 64'h80000024, 5'd0, 5'd31, 5'd1,
                64'd10, 64'hFFFFFFFFFFFFFFFF, 64'd0, 64'd0, 8'b10100100};
    tbl[9]  = '{1, 32'h800002B7, 64'h100, 5'd0, 5'd0, 5'd5,
                64'd0, 64'h80000000, 64'd0, 64'd0, 8'b00100100};
    tbl[10] = '{1, 32'hFFF00093, 64'h104, 5'd0, 5'd31, 5'd1,
                64'd10, 64'hFFFFFFFF, 64'd0, 64'd0, 8'b10100100};
    tbl[11] = '{1, 32'h00113423, 64'h108, 5'd2, 5'd1, 5'd0,
                64'd0, 64'd0, 64'd0, 64'd0, 8'b00000001};

    a_flush = 0; a_in_valid = 0; a_in_inst = '0; a_in_pc = '0;
    a_out_ready = 1; a_rs1data = 64'd10; a_rs2data = 64'd20;
    b_flush = 0; b_in_valid = 0; b_in_inst = '0; b_in_pc = '0;
    b_out_ready = 1; b_rs1data = 32'd10; b_rs2data = 32'd20;

    // reset state
    tick();
    chk("rst in_ready", 64'(a_in_ready), 64'd0);
    chk("rst out_valid", 64'(a_out_valid), 64'd0);
    chk("rst alu_op2", a_out_alu_op2, 64'd0);
    chk("rst flags", 64'(a_flags), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("post-rst in_ready", 64'(a_in_ready), 64'd1);
    tick();

    // decode table
    for (int i = 0; i < 12; i++) run_vec(tbl[i], i);

    // back-to-back throughput
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      a_in_inst = mk_addi(k);
      tick();
      chk("thru in_ready", 64'(a_in_ready), 64'd1);
      if (k >= 2) begin
        chk("thru valid", 64'(a_out_valid), 64'd1);
        chk("thru order", a_out_alu_op2, 64'(k - 1));
      end
    end
    a_in_valid = 1'b0;
    tick();
    chk("thru last", a_out_alu_op2, 64'd4);
    tick();
    chk("thru idle", 64'(a_out_valid), 64'd0);

    // backpressure: DEPTH+1 accepted, payload held while stalled
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_inst   = mk_addi(1);
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      fire = a_in_ready;
      tick();
      if (fire) begin
        acc++;
        a_in_inst = mk_addi(acc + 1);
      end
      if (a_out_valid) chk("stall hold", a_out_alu_op2, 64'd1);
    end
    a_in_valid = 1'b0;
    chk("bp accepted", 64'(acc), 64'd3);
    chk("bp in_ready", 64'(a_in_ready), 64'd0);
    a_out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      chk("drain valid", 64'(a_out_valid), 64'd1);
      chk("drain order", a_out_alu_op2, 64'(k));
      tick();
    end
    chk("drain done", 64'(a_out_valid), 64'd0);

    // flush while full, with a same-cycle offer
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    for (int k = 5; k <= 7; k++) begin
      a_in_inst = mk_addi(k);
      tick();
    end
    chk("pre-flush full", 64'(a_in_ready), 64'd0);
    chk("pre-flush valid", 64'(a_out_valid), 64'd1);
    a_in_inst = mk_addi(9);
    a_flush   = 1'b1;
    tick();
    a_flush    = 1'b0;
    a_in_valid = 1'b0;
    chk("flush valid", 64'(a_out_valid), 64'd0);
    chk("flush in_ready", 64'(a_in_ready), 64'd1);
    a_out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (a_out_valid) seen++;
    end
    chk("flush no replay", 64'(seen), 64'd0);

    // flush drops an offer that would otherwise be pushed
    a_in_valid = 1'b1;
    a_in_inst  = mk_addi(10);
    a_flush    = 1'b1;
    tick();
    a_flush    = 1'b0;
    a_in_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (a_out_valid) seen++;
    end
    chk("flush drop push", 64'(seen), 64'd0);

    // asynchronous reset mid-stream on the 32-bit instance
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1;
    b_in_inst   = 32'h800002B7;
    tick();
    b_in_inst   = 32'hFFF00093;
    tick();
    b_in_valid  = 1'b0;
    tick();
    chk("pre-rst valid", 64'(b_out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst valid", 64'(b_out_valid), 64'd0);
    chk("async rst ready", 64'(b_in_ready), 64'd0);
    chk("async rst op2", 64'(b_out_alu_op2), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst rel ready", 64'(b_in_ready), 64'd1);
    b_out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (b_out_valid) seen++;
    end
    chk("rst queue empty", 64'(seen), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
